// File: rtl/fu_issue_queue_if.sv
// Producer/FU-side bundle of fu_issue_queue.
// The master is the producer/observer side; the slave is the issue queue itself.
interface fu_issue_if #(
  parameter int TAG_W = 4
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_c;
  logic [4:0]       in_inst;
  logic             in_ci;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [31:0]      fu_c;
  logic [4:0]       fu_inst;
  logic             fu_ci;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output flush, in_valid, in_a, in_b, in_c, in_inst, in_ci, in_tag,
    input  in_ready, fu_a, fu_b, fu_c, fu_inst, fu_ci, res_valid, res_tag
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, in_c, in_inst, in_ci, in_tag,
    output in_ready, fu_a, fu_b, fu_c, fu_inst, fu_ci, res_valid, res_tag
  );
endinterface

// File: rtl/fu_issue_queue.sv
// fu_issue_queue: issue stage in front of the Mosaic functional unit.
// Ops are buffered in a small FIFO and presented one at a time on the FU
// lines, held stable for L+1 cycles (L = MADD_LAT for MADD, else 1); the
// last of those cycles is flagged with res_valid/res_tag. FU lines read zero
// when idle so the FU gated clocks stay off.
// Optional feature macro: FU_ISSUE_PERF_EN adds the 16-bit saturating
// stall_cnt output (cycles with in_valid high while in_ready is low).
module fu_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int MADD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  fu_issue_if.slave  bus
`ifdef FU_ISSUE_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (MADD_LAT > 1) ? $clog2(MADD_LAT) : 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      c;
    logic [4:0]       inst;
    logic             ci;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  op_t              mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  op_t              op_reg, op_next;

  op_t              in_op;
  op_t              head_op;
  logic [CNT_W-1:0] head_cnt;
  logic             full, empty, in_ready, push, pop, res_valid;

  assign in_op    = '{a: bus.in_a, b: bus.in_b, c: bus.in_c,
                      inst: bus.in_inst, ci: bus.in_ci, tag: bus.in_tag};
  assign head_op  = mem[rd_ptr_reg];
  // Remaining EXEC cycles after the first: MADD needs MADD_LAT edges, others one.
  assign head_cnt = (head_op.inst[4:3] == 2'b11) ? CNT_W'(MADD_LAT - 1) : '0;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  // Ready is held low during reset and flush so nothing sneaks in around them.
  assign in_ready = !full && !bus.flush && !rst;
  assign push     = bus.in_valid && in_ready;

  // FIFO storage write; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_op;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Issue FSM state, latency counter and held op registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  // Next-state logic: pop from IDLE or straight out of RESULT to avoid a bubble.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    pop        = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
      cnt_next   = '0;
      op_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!empty) begin
            pop        = 1'b1;
            op_next    = head_op;
            cnt_next   = head_cnt;
            state_next = EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            state_next = RESULT;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        RESULT: begin
          if (!empty) begin
            pop        = 1'b1;
            op_next    = head_op;
            cnt_next   = head_cnt;
            state_next = EXEC;
          end else begin
            op_next    = '0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          op_next    = '0;
        end
      endcase
    end
  end

  // The held op register is zero whenever idle, so it drives the FU lines directly.
  assign res_valid     = (state_reg == RESULT) && !bus.flush;
  assign bus.in_ready  = in_ready;
  assign bus.fu_a      = op_reg.a;
  assign bus.fu_b      = op_reg.b;
  assign bus.fu_c      = op_reg.c;
  assign bus.fu_inst   = op_reg.inst;
  assign bus.fu_ci     = op_reg.ci;
  assign bus.res_valid = res_valid;
  assign bus.res_tag   = res_valid ? op_reg.tag : '0;

`ifdef FU_ISSUE_PERF_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of producer stall cycles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (bus.in_valid && !in_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
